// File: rtl/axi_burst_traffic_seq.sv
`default_nettype none
// ============================================================================
// Module   : axi_burst_traffic_seq
// Brief    : Drives axi_burst_master to write a seeded pattern over N bursts,
//            reads the region back and counts data/response errors.
//            Optional macro AXI_TGEN_RSTALL_EN adds LFSR read backpressure.
// Revision : 1.0
// ============================================================================
module axi_burst_traffic_seq #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  cfg_start,
    input  logic [1:0]            cfg_mode,
    input  logic [ADDR_W-1:0]     cfg_base_addr,
    input  logic [15:0]           cfg_num_bursts,
    input  logic [7:0]            cfg_burst_len,
    input  logic [31:0]           cfg_seed,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err,
    output logic [15:0]           err_cnt,
    output logic [7:0]            resp_err_cnt,
    output logic                  first_err_valid,
    output logic [ADDR_W-1:0]     first_err_addr,
    output logic                  user_start,
    output logic                  user_w_r,
    output logic [7:0]            user_burst_len_in,
    output logic [ADDR_W-1:0]     user_addr_in,
    output logic [DATA_W-1:0]     user_data_in,
    output logic [DATA_W/8-1:0]   user_data_strb,
    output logic                  user_stall_r_data,
    input  logic                  user_free,
    input  logic                  user_stall_w_data,
    input  logic [1:0]            user_status,
    input  logic [DATA_W-1:0]     user_data_out,
    input  logic                  user_data_out_en
);
    localparam int C_BYTES = DATA_W / 8;
    localparam int C_BSH   = $clog2(C_BYTES);
    localparam int C_WORDS = DATA_W / 32;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_W_REQ  = 3'd1,
        S_W_BEAT = 3'd2,
        S_W_RESP = 3'd3,
        S_R_REQ  = 3'd4,
        S_R_BEAT = 3'd5,
        S_R_RESP = 3'd6,
        S_DONE   = 3'd7
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [1:0]          r_mode;
    logic [ADDR_W-1:0]   r_base;
    logic [15:0]         r_nb;
    logic [7:0]          r_len;
    logic [31:0]         r_seed;
    logic [15:0]         r_burst;
    logic [7:0]          r_beat;
    logic [31:0]         r_kbase;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_start;
    logic                r_wr;
    logic                r_busy;
    logic                r_done;
    logic                r_cfg_err;
    logic [15:0]         r_err;
    logic [7:0]          r_resp;
    logic                r_fev;
    logic [ADDR_W-1:0]   r_faddr;

    logic                w_bad_cfg;
    logic                w_accept;
    logic                w_req_acc;
    logic                w_last_burst;
    logic                w_last_beat;
    logic                w_resp_bad;
    logic                w_burst_end;
    logic [31:0]         w_k;
    logic [DATA_W-1:0]   w_pat;
    logic [ADDR_W-1:0]   w_stride;

    assign w_bad_cfg    = (cfg_mode == 2'b11) || (cfg_num_bursts == 16'd0) ||
                          (cfg_base_addr[C_BSH-1:0] != '0);
    assign w_accept     = (r_state == S_IDLE) && cfg_start && !w_bad_cfg;
    assign w_req_acc    = r_start && !user_free;
    assign w_last_burst = (r_burst == r_nb - 16'd1);
    assign w_last_beat  = (r_beat == r_len);
    // Pattern index is global across the phase: burst base index plus beat.
    assign w_k          = r_seed + r_kbase + {24'd0, r_beat};
    assign w_pat        = {C_WORDS{w_k}};
    assign w_stride     = ADDR_W'({1'b0, r_len} + 9'd1) << C_BSH;
    assign w_resp_bad   = (user_status != 2'b00) &&
                          (((r_state == S_W_RESP) && user_free) ||
                           ((r_state == S_R_BEAT) && user_data_out_en));
    assign w_burst_end  = ((r_state == S_W_RESP) || (r_state == S_R_RESP)) && user_free;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_next = (cfg_mode == 2'b01) ? S_R_REQ : S_W_REQ;
            S_W_REQ:  if (w_req_acc) w_next = S_W_BEAT;
            S_W_BEAT: if (user_stall_w_data && w_last_beat) w_next = S_W_RESP;
            S_W_RESP: if (user_free)
                          w_next = !w_last_burst ? S_W_REQ :
                                   ((r_mode == 2'b10) ? S_R_REQ : S_DONE);
            S_R_REQ:  if (w_req_acc) w_next = S_R_BEAT;
            // An early user_free closes the burst; missing beats are not errors.
            S_R_BEAT: if ((user_data_out_en && w_last_beat) || (user_free && !user_data_out_en))
                          w_next = S_R_RESP;
            S_R_RESP: if (user_free) w_next = w_last_burst ? S_DONE : S_R_REQ;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_mode <= '0; r_base <= '0; r_nb <= '0; r_len <= '0; r_seed <= '0;
            r_burst <= '0; r_beat <= '0; r_kbase <= '0; r_addr <= '0;
            r_start <= 1'b0; r_wr <= 1'b0; r_busy <= 1'b0; r_done <= 1'b0;
            r_cfg_err <= 1'b0; r_err <= '0; r_resp <= '0; r_fev <= 1'b0; r_faddr <= '0;
        end else begin
            r_start <= (w_next == S_W_REQ) || (w_next == S_R_REQ);
            r_wr    <= (w_next == S_R_REQ) || (w_next == S_R_BEAT) || (w_next == S_R_RESP);
            r_busy  <= (w_next != S_IDLE) && (w_next != S_DONE);
            r_done  <= (w_next == S_DONE);
            if ((r_state == S_IDLE) && cfg_start) begin
                if (w_bad_cfg) begin
                    r_cfg_err <= 1'b1;
                end else begin
                    r_mode <= cfg_mode; r_base <= cfg_base_addr; r_nb <= cfg_num_bursts;
                    r_len <= cfg_burst_len; r_seed <= cfg_seed;
                    r_burst <= '0; r_beat <= '0; r_kbase <= '0; r_addr <= cfg_base_addr;
                    r_cfg_err <= 1'b0; r_err <= '0; r_resp <= '0; r_fev <= 1'b0;
                end
            end
            if (w_req_acc) r_beat <= '0;
            if ((r_state == S_W_BEAT) && user_stall_w_data) r_beat <= r_beat + 8'd1;
            if ((r_state == S_R_BEAT) && user_data_out_en) begin
                r_beat <= r_beat + 8'd1;
                if (user_data_out != w_pat) begin
                    if (r_err != '1) r_err <= r_err + 16'd1;
                    if (!r_fev) begin
                        r_fev   <= 1'b1;
                        r_faddr <= r_addr + (ADDR_W'(r_beat) << C_BSH);
                    end
                end
            end
            if (w_resp_bad && (r_resp != '1)) r_resp <= r_resp + 8'd1;
            if (w_burst_end) begin
                if (w_last_burst) begin
                    // Read phase restarts at burst 0 / index 0.
                    r_burst <= '0; r_kbase <= '0; r_addr <= r_base;
                end else begin
                    r_burst <= r_burst + 16'd1;
                    r_kbase <= r_kbase + {24'd0, r_len} + 32'd1;
                    r_addr  <= r_addr + w_stride;
                end
            end
        end
    end

    assign busy              = r_busy;
    assign done              = r_done;
    assign cfg_err           = r_cfg_err;
    assign err_cnt           = r_err;
    assign resp_err_cnt      = r_resp;
    assign first_err_valid   = r_fev;
    assign first_err_addr    = r_faddr;
    assign user_start        = r_start;
    assign user_w_r          = r_wr;
    assign user_burst_len_in = r_len;
    assign user_addr_in      = r_addr;
    assign user_data_in      = w_pat;
    assign user_data_strb    = {C_BYTES{r_busy}};

`ifdef AXI_TGEN_RSTALL_EN
    logic [15:0] r_lfsr;
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_lfsr <= 16'hACE1;
        else          r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
    assign user_stall_r_data = (r_state == S_R_BEAT) && r_lfsr[0] && r_lfsr[1];
`else
    assign user_stall_r_data = 1'b0;
`endif

endmodule
`default_nettype wire
